mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of the ALU. It consumes the ALU result
//  as a data address (lw/sw) or as a pass-through value (addu/addiu/jal).
//  It runs a req/ack transaction to data memory and presents write-back data to
//  the register-file stage over a valid/ready handshake. It buffers one instruction.
// PARAMETERS
//  DATA_W    32  data/address width
//  REG_AW    5   register-index width
//  TIMEOUT   16  max cycles waiting for mem_ack before error (>=2)
// PORTS
//  clk            in   1       single clock, rising edge
//  rst_n          in   1       asynchronous, active-low reset
//  in_valid       in   1       upstream (ALU) instruction valid
//  in_ready       out  1       stage can accept an instruction this cycle
//  in_op          in   2       mem_op_t: OP_NONE / OP_LOAD / OP_STORE
//  in_alu_result  in   DATA_W  ALU result: address or pass-through value
//  in_store_data  in   DATA_W  rt value for sw
//  in_wb_reg      in   REG_AW  destination register
//  in_wb_en       in   1       instruction writes a register
//  mem_req        out  1       memory request, held until mem_ack
//  mem_we         out  1       1 = write (sw), 0 = read (lw)
//  mem_addr       out  DATA_W  address, stable while mem_req
//  mem_wdata      out  DATA_W  write data, stable while mem_req
//  mem_ack        in   1       memory completes this cycle
//  mem_rdata      in   DATA_W  read data, valid with mem_ack
//  out_valid      out  1       write-back bundle valid
//  out_ready      in   1       downstream accepts bundle
//  out_wb_data    out  DATA_W  load data or pass-through result
//  out_wb_reg     out  REG_AW  destination register
//  out_wb_en      out  1       register write enable (0 for sw/error)
//  out_err        out  1       bus timeout (or misalign, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 except in_ready=1; timeout counter 0.
//  FSM states: IDLE, REQ, HOLD.
//   IDLE: in_ready=1. On in_valid:
//    - OP_NONE: latch result/reg/wb_en -> HOLD next cycle (1-cycle latency).
//    - OP_LOAD/OP_STORE: latch addr/wdata/we -> REQ.
//   REQ: mem_req=1, in_ready=0, and the counter increments each cycle.
//    - mem_ack: capture mem_rdata (load) -> HOLD. sw forces out_wb_en=0.
//    - No ack with counter==TIMEOUT-1: drop mem_req -> HOLD with out_err=1 and out_wb_en=0.
//    - ack and timeout in the same cycle: ack wins, err=0.
//   HOLD: out_valid=1 and outputs stable until out_ready.
//    - in_ready = out_ready, so back-to-back acceptance is possible.
//    - out_ready & in_valid: load the new instruction as in IDLE (0 bubble).
//    - out_ready & !in_valid -> IDLE.
//  Minimum latency: pass-through 1 cycle; memory op 2 cycles + wait states.
//  mem_ack outside REQ is ignored.
//  in_* signals are sampled only when in_valid & in_ready.
//  Reset mid-transaction: mem_req and out_valid drop immediately (async).
//  Any ack that arrives later is ignored.
//  Width rules: addresses pass unmodified (byte address). Timeout counter is
//  $clog2(TIMEOUT) bits and saturates and clears on REQ entry.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined:
//   - OP_LOAD/OP_STORE with addr[1:0]!=0 skips REQ.
//   - Goes IDLE->HOLD with out_err=1, out_wb_en=0, no mem_req.
//  Not defined: no alignment check; addr[1:0] is passed to memory unchanged.
// STRUCTURE
//  mips_pkg: mem_op_t enum (OP_NONE=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10),
//  mem_state_t (IDLE, REQ, HOLD), and a wb_bundle_t struct (data, reg, en, err).
//  Single flat module. No sub-module is needed: the timeout counter is inline.
// TESTING
//  1 OP_NONE, alu=32'h0000_0010, reg=5'd3, out_ready=1
//    -> next cycle out_valid, wb_data=0x10, reg=3, en=1, err=0.
//  2 OP_LOAD addr=0x100, ack 3 cycles later with rdata=0xDEADBEEF
//    -> mem_req high 3 cycles with addr stable, then out_wb_data=0xDEADBEEF, en=1.
//  3 OP_STORE addr=0x104, wdata=0x1234, ack same cycle as req
//    -> mem_we=1, out_valid next cycle, out_wb_en=0.
//  4 OP_LOAD, no ack for TIMEOUT=16 cycles -> mem_req drops after 16 cycles, out_err=1,
//    en=0; an ack at cycle 16 instead gives err=0.
//  5 out_ready=0 for 4 cycles in HOLD -> outputs stable and in_ready=0.
//    Releasing out_ready with in_valid gives zero-bubble acceptance.
//  6 rst_n low during REQ -> mem_req=0 and out_valid=0 immediately, state IDLE.
//    With MEM_ALIGN_CHECK_EN, addr=0x102 -> err=1 and no mem_req.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types for the memory-access stage.
package mips_pkg;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  dst;
        logic        en;
        logic        err;
    } wb_bundle_t;

endpackage

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: req/ack data memory port, one-entry write-back buffer.
// Optional MEM_ALIGN_CHECK_EN: misaligned lw/sw skip memory and return out_err.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [REG_AW-1:0] in_wb_reg,
    input  logic              in_wb_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_wb_data,
    output logic [REG_AW-1:0] out_wb_reg,
    output logic              out_wb_en,
    output logic              out_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_t    state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          accept, is_mem, misalign, ack_hit, timeout_hit;

    assign is_mem = (in_op == OP_LOAD) || (in_op == OP_STORE);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = |in_alu_result[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign mem_req   = (state == REQ);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        in_ready    = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: in_ready = 1'b1;
            REQ: begin
                cnt_next = (cnt == CNT_LAST) ? cnt : cnt + 1'b1;
                // An ack in the final wait cycle still counts as success.
                if (mem_ack) begin
                    ack_hit    = 1'b1;
                    state_next = HOLD;
                end else if (cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        accept = in_valid & in_ready;
        if (accept) begin
            if (is_mem && !misalign) begin
                state_next = REQ;
                cnt_next   = '0;
            end else begin
                state_next = HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            out_wb_data <= '0;
            out_wb_reg  <= '0;
            out_wb_en   <= 1'b0;
            out_err     <= 1'b0;
        end else if (accept) begin
            out_wb_reg <= in_wb_reg;
            if (is_mem) begin
                mem_we      <= (in_op == OP_STORE);
                mem_addr    <= in_alu_result;
                mem_wdata   <= in_store_data;
                out_wb_data <= '0;
                out_wb_en   <= in_wb_en && (in_op == OP_LOAD) && !misalign;
                out_err     <= misalign;
            end else begin
                out_wb_data <= in_alu_result;
                out_wb_en   <= in_wb_en;
                out_err     <= 1'b0;
            end
        end else if (ack_hit) begin
            if (!mem_we) out_wb_data <= mem_rdata;
        end else if (timeout_hit) begin
            out_wb_en <= 1'b0;
            out_err   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage.
module tb_mem_stage;
    import mips_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_wb_reg;
    logic        in_wb_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_wb_data;
    logic [4:0]  out_wb_reg;
    logic        out_wb_en;
    logic        out_err;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_stage #(.DATA_W(32), .REG_AW(5), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_wb_reg(in_wb_reg), .in_wb_en(in_wb_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wb_data(out_wb_data), .out_wb_reg(out_wb_reg),
        .out_wb_en(out_wb_en), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic logic misaligned(input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Expected write-back outcome of one instruction, given when memory answers.
    function automatic wb_bundle_t ref_bundle(input logic [1:0] op, input logic [31:0] alu,
                                              input logic [4:0] rg, input logic en,
                                              input int ack_wait, input logic [31:0] rdata);
        wb_bundle_t b;
        b.dst = rg; b.data = 32'h0; b.en = 1'b0; b.err = 1'b0;
        if (op == OP_LOAD || op == OP_STORE) begin
            if (misaligned(alu) || ack_wait >= TIMEOUT) b.err = 1'b1;
            else if (op == OP_LOAD) begin b.data = rdata; b.en = en; end
        end else begin
            b.data = alu; b.en = en;
        end
        return b;
    endfunction

    task automatic scramble_inputs();
        in_op = 2'($urandom); in_alu_result = $urandom; in_store_data = $urandom;
        in_wb_reg = 5'($urandom); in_wb_en = 1'($urandom);
    endtask

    // Issues one instruction from idle, answers the memory port, checks the result.
    task automatic run_instr(input string nm, input logic [1:0] op, input logic [31:0] alu,
                             input logic [31:0] sd, input logic [4:0] rg, input logic en,
                             input int ack_wait, input logic [31:0] rdata, input int stall);
        wb_bundle_t exp;
        int exp_req, req_cycles;
        logic goes_mem, data_known;
        exp = ref_bundle(op, alu, rg, en, ack_wait, rdata);
        goes_mem = (op == OP_LOAD || op == OP_STORE) && !misaligned(alu);
        exp_req = !goes_mem ? 0 : (ack_wait < TIMEOUT ? ack_wait + 1 : TIMEOUT);
        data_known = (op == OP_NONE) || (op == OP_LOAD && !exp.err);
        in_valid = 1'b1; in_op = op; in_alu_result = alu; in_store_data = sd;
        in_wb_reg = rg; in_wb_en = en; out_ready = (stall == 0);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s.in_ready_idle got %b want 1", nm, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        scramble_inputs();
        req_cycles = 0;
        while (mem_req && req_cycles < TIMEOUT + 4) begin
            n_cmp++;
            if (mem_addr !== alu || mem_we !== (op == OP_STORE) ||
                (op == OP_STORE && mem_wdata !== sd)) begin
                n_fail++;
                $display("FAIL %s.mem_port got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                         nm, mem_addr, mem_we, mem_wdata, alu, op == OP_STORE, sd);
            end
            mem_ack   = (req_cycles == ack_wait);
            mem_rdata = mem_ack ? rdata : $urandom;
            req_cycles++;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        n_cmp++;
        if (req_cycles != exp_req) begin n_fail++; $display("FAIL %s.req_cycles got %0d want %0d", nm, req_cycles, exp_req); end
        for (int s = 0; s <= stall; s++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_wb_reg !== exp.dst || out_wb_en !== exp.en ||
                out_err !== exp.err || (data_known && out_wb_data !== exp.data)) begin
                n_fail++;
                $display("FAIL %s.bundle[%0d] got v=%b d=%h r=%0d en=%b err=%b want v=1 d=%h r=%0d en=%b err=%b",
                         nm, s, out_valid, out_wb_data, out_wb_reg, out_wb_en, out_err,
                         exp.data, exp.dst, exp.en, exp.err);
            end
            if (s < stall) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL %s.in_ready_stall got %b want 0", nm, in_ready); end
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s.drain got v=%b req=%b want 0 0", nm, out_valid, mem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b1;
        scramble_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || out_valid !== 1'b0 || out_wb_data !== 32'h0 ||
            out_wb_reg !== 5'h0 || out_wb_en !== 1'b0 || out_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset got rdy=%b req=%b we=%b a=%h wd=%h v=%b d=%h r=%0d en=%b err=%b want rdy=1 rest 0",
                     in_ready, mem_req, mem_we, mem_addr, mem_wdata, out_valid, out_wb_data,
                     out_wb_reg, out_wb_en, out_err);
        end
    endtask

    task automatic test_passthrough();
        run_instr("pass_dir", OP_NONE, 32'h0000_0010, 32'h0, 5'd3, 1'b1, 0, 32'h0, 0);
        for (int i = 0; i < 6; i++)
            run_instr("pass_rnd", OP_NONE, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 32'h0, 0);
    endtask

    task automatic test_load();
        run_instr("load_dir", OP_LOAD, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 2, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 8; i++)
            run_instr("load_rnd", OP_LOAD, $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom),
                      1'($urandom), int'($urandom_range(0, 6)), $urandom, 0);
    endtask

    task automatic test_store();
        run_instr("store_dir", OP_STORE, 32'h0000_0104, 32'h0000_1234, 5'd9, 1'b1, 0, 32'h0, 0);
        for (int i = 0; i < 6; i++)
            run_instr("store_rnd", OP_STORE, $urandom & 32'hFFFF_FFFC, $urandom, 5'($urandom),
                      1'b1, int'($urandom_range(0, 6)), $urandom, 0);
    endtask

    task automatic test_timeout();
        run_instr("timeout", OP_LOAD, 32'h0000_0200, 32'h0, 5'd4, 1'b1, TIMEOUT + 5, 32'h0, 0);
        run_instr("ack_last", OP_LOAD, 32'h0000_0204, 32'h0, 5'd5, 1'b1, TIMEOUT - 1, 32'hCAFE_F00D, 0);
        run_instr("st_timeout", OP_STORE, 32'h0000_0208, 32'h55, 5'd6, 1'b1, TIMEOUT + 1, 32'h0, 0);
    endtask

    task automatic test_stall();
        logic [31:0] b_data;
        run_instr("stall_load", OP_LOAD, 32'h0000_0300, 32'h0, 5'd11, 1'b1, 1, 32'h1357_9BDF, 4);
        run_instr("stall_pass", OP_NONE, 32'hA5A5_5A5A, 32'h0, 5'd12, 1'b1, 0, 32'h0, 4);
        // Held bundle, then release out_ready together with a new instruction.
        in_valid = 1'b1; in_op = OP_NONE; in_alu_result = 32'h1111_2222; in_wb_reg = 5'd1; in_wb_en = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        b_data = $urandom;
        in_op = OP_NONE; in_alu_result = b_data; in_wb_reg = 5'd2; in_wb_en = 1'b1;
        repeat (4) begin
            #1;
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_wb_data !== 32'h1111_2222) begin
                n_fail++;
                $display("FAIL zb_hold got rdy=%b v=%b d=%h want 0 1 11112222", in_ready, out_valid, out_wb_data);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL zb_ready got %b want 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_wb_data !== b_data || out_wb_reg !== 5'd2) begin
            n_fail++;
            $display("FAIL zb_next got v=%b d=%h r=%0d want 1 %h 2", out_valid, out_wb_data, out_wb_reg, b_data);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        wb_bundle_t held;
        logic have, exp_ready;
        have = 1'b0; held = '0;
        for (int c = 0; c < 200; c++) begin
            n_cmp++;
            if (out_valid !== have || (have && (out_wb_data !== held.data ||
                out_wb_reg !== held.dst || out_wb_en !== held.en || out_err !== 1'b0))) begin
                n_fail++;
                $display("FAIL b2b[%0d] got v=%b d=%h r=%0d en=%b err=%b want v=%b d=%h r=%0d en=%b err=0",
                         c, out_valid, out_wb_data, out_wb_reg, out_wb_en, out_err,
                         have, held.data, held.dst, held.en);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op = OP_NONE; in_alu_result = $urandom; in_store_data = $urandom;
            in_wb_reg = 5'($urandom); in_wb_en = 1'($urandom);
            #1;
            exp_ready = !have || out_ready;
            n_cmp++;
            if (in_ready !== exp_ready) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want %b", c, in_ready, exp_ready); end
            if (have && out_ready) have = 1'b0;
            if (in_valid && exp_ready) begin
                have = 1'b1;
                held = '{data: in_alu_result, dst: in_wb_reg, en: in_wb_en, err: 1'b0};
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_op = OP_LOAD; in_alu_result = 32'h0000_0400; in_wb_reg = 5'd8; in_wb_en = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_req got %b want 1", mem_req); end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_async got req=%b v=%b rdy=%b want 0 0 1", mem_req, out_valid, in_ready);
        end
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL late_ack got req=%b v=%b want 0 0", mem_req, out_valid);
        end
        mem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
        run_instr("misalign_ld", OP_LOAD, 32'h0000_0102, 32'h0, 5'd10, 1'b1, 0, 32'h7777_7777, 0);
        run_instr("misalign_st", OP_STORE, 32'h0000_0101, 32'h99, 5'd10, 1'b1, 0, 32'h0, 0);
`else
        run_instr("unaligned_ld", OP_LOAD, 32'h0000_0102, 32'h0, 5'd10, 1'b1, 1, 32'h7777_7777, 0);
        run_instr("unaligned_st", OP_STORE, 32'h0000_0103, 32'h99, 5'd10, 1'b1, 0, 32'h0, 0);
`endif
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load();
        test_store();
        test_timeout();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_align();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
